// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider bank.
package clk_div_pkg;

    localparam logic        MODE_TOGGLE = 1'b0;
    localparam logic        MODE_PULSE  = 1'b1;
    localparam logic [31:0] DEFAULT_DIV = 32'd5000000;

    // Channel index width, never narrower than one bit.
    function automatic int chan_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active and pending divisor/mode,
// and registered divided-clock / tick outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(clk_div_pkg::DEFAULT_DIV)
)(
    input  logic             iClk,
    input  logic             nRst,
    input  logic             iWr,
    input  logic [WIDTH-1:0] iWrDiv,
    input  logic             iWrMode,
    input  logic             iEn,
    input  logic             iSync,
    output logic             oClk,
    output logic             oTick,
    output logic             oPending
);

    logic [WIDTH-1:0] countReg;
    logic [WIDTH-1:0] actDivReg;
    logic [WIDTH-1:0] pendDivReg;
    logic             actModeReg;
    logic             pendModeReg;
    logic             pendReg;
    logic             clkReg;
    logic             tickReg;

    logic [WIDTH-1:0] countInc;
    logic             halted;
    logic             isEvent;
    logic             doApply;

    assign countInc = countReg + WIDTH'(1);
    assign halted   = iSync || !iEn || (actDivReg == '0);
    assign isEvent  = !halted && (countInc == actDivReg);
    // Pending values only move to active at a period boundary or while idle,
    // so a divisor change never produces a short or long period.
    assign doApply  = pendReg && (halted || isEvent);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            countReg    <= '0;
            actDivReg   <= DEFAULT_DIV;
            pendDivReg  <= '0;
            actModeReg  <= MODE_TOGGLE;
            pendModeReg <= MODE_TOGGLE;
            pendReg     <= 1'b0;
            clkReg      <= 1'b0;
            tickReg     <= 1'b0;
        end else begin
            if (halted) begin
                countReg <= '0;
                clkReg   <= 1'b0;
                tickReg  <= 1'b0;
            end else if (isEvent) begin
                countReg <= '0;
                tickReg  <= 1'b1;
                clkReg   <= (actModeReg == MODE_PULSE) ? 1'b1 : ~clkReg;
            end else begin
                countReg <= countInc;
                tickReg  <= 1'b0;
                if (actModeReg == MODE_PULSE) begin
                    clkReg <= 1'b0;
                end
            end

            if (doApply) begin
                actDivReg  <= pendDivReg;
                actModeReg <= pendModeReg;
            end

            // A write on the apply edge stays pending; the apply used the old slot.
            if (iWr) begin
                pendDivReg  <= iWrDiv;
                pendModeReg <= iWrMode;
                pendReg     <= 1'b1;
            end else if (doApply) begin
                pendReg <= 1'b0;
            end
        end
    end

    assign oClk     = clkReg;
    assign oTick    = tickReg;
    assign oPending = pendReg;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers sharing one
// write port and a global phase-align strobe.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int               CHANNELS    = 4,
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(clk_div_pkg::DEFAULT_DIV),
    localparam int              CW          = chan_idx_width(CHANNELS)
)(
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iWrEn,
    input  logic [CW-1:0]       iWrChan,
    input  logic [WIDTH-1:0]    iWrDiv,
    input  logic                iWrMode,
    input  logic [CHANNELS-1:0] iEn,
    input  logic                iSync,
    output logic [CHANNELS-1:0] oClk,
    output logic [CHANNELS-1:0] oTick,
    output logic [CHANNELS-1:0] oPending
);

    logic [CHANNELS-1:0] wrHit;

    // Out-of-range channel indices match no strobe and are dropped.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign wrHit[gi] = iWrEn && (iWrChan == CW'(gi));

            clk_div_chan #(
                .WIDTH       (WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .iClk     (iClk),
                .nRst     (nRst),
                .iWr      (wrHit[gi]),
                .iWrDiv   (iWrDiv),
                .iWrMode  (iWrMode),
                .iEn      (iEn[gi]),
                .iSync    (iSync),
                .oClk     (oClk[gi]),
                .oTick    (oTick[gi]),
                .oPending (oPending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_clk_div_bank;

    localparam int CH   = 4;
    localparam int W    = 16;
    localparam int DDIV = 3;

    logic          iClk = 1'b0;
    logic          nRst = 1'b0;
    logic          iWrEn = 1'b0;
    logic [1:0]    iWrChan = '0;
    logic [W-1:0]  iWrDiv = '0;
    logic          iWrMode = 1'b0;
    logic [CH-1:0] iEn = '0;
    logic          iSync = 1'b0;
    logic [CH-1:0] oClk;
    logic [CH-1:0] oTick;
    logic [CH-1:0] oPending;

    int nCmp = 0;
    int nBad = 0;

    clk_div_bank #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (W'(DDIV))
    ) dut (
        .iClk     (iClk),
        .nRst     (nRst),
        .iWrEn    (iWrEn),
        .iWrChan  (iWrChan),
        .iWrDiv   (iWrDiv),
        .iWrMode  (iWrMode),
        .iEn      (iEn),
        .iSync    (iSync),
        .oClk     (oClk),
        .oTick    (oTick),
        .oPending (oPending)
    );

    always #5 iClk = ~iClk;

    // Behavioural model: per channel, edges elapsed in the current period,
    // the divisor/mode in force, and the latest unapplied write.
    int unsigned   mDiv [CH];
    int unsigned   mPDiv[CH];
    int unsigned   mRun [CH];
    bit            mMode[CH];
    bit            mPMode[CH];
    logic [CH-1:0] expClk;
    logic [CH-1:0] expTick;
    logic [CH-1:0] expPend;

    always @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            for (int c = 0; c < CH; c++) begin
                mDiv[c]  <= DDIV;
                mMode[c] <= 1'b0;
                mPDiv[c] <= 0;
                mPMode[c] <= 1'b0;
                mRun[c]  <= 0;
            end
            expClk  <= '0;
            expTick <= '0;
            expPend <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                bit stopped;
                bit periodEnd;
                stopped   = iSync || !iEn[c] || (mDiv[c] == 0);
                periodEnd = !stopped && (mRun[c] + 1 == mDiv[c]);
                if (stopped) begin
                    mRun[c]    <= 0;
                    expClk[c]  <= 1'b0;
                    expTick[c] <= 1'b0;
                end else if (periodEnd) begin
                    mRun[c]    <= 0;
                    expTick[c] <= 1'b1;
                    expClk[c]  <= mMode[c] ? 1'b1 : !expClk[c];
                end else begin
                    mRun[c]    <= mRun[c] + 1;
                    expTick[c] <= 1'b0;
                    if (mMode[c]) expClk[c] <= 1'b0;
                end
                if (expPend[c] && (stopped || periodEnd)) begin
                    mDiv[c]    <= mPDiv[c];
                    mMode[c]   <= mPMode[c];
                    expPend[c] <= 1'b0;
                end
                if (iWrEn && (int'(iWrChan) == c)) begin
                    mPDiv[c]   <= int'(iWrDiv);
                    mPMode[c]  <= iWrMode;
                    expPend[c] <= 1'b1;
                end
            end
        end
    end

    always @(negedge iClk) begin
        if (nRst) begin
            nCmp += 3;
            if (oClk !== expClk) begin
                nBad++;
                $display("FAIL model_oClk t=%0t dut=%b model=%b", $time, oClk, expClk);
            end
            if (oTick !== expTick) begin
                nBad++;
                $display("FAIL model_oTick t=%0t dut=%b model=%b", $time, oTick, expTick);
            end
            if (oPending !== expPend) begin
                nBad++;
                $display("FAIL model_oPending t=%0t dut=%b model=%b", $time, oPending, expPend);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic doWrite(input int ch, input int dv, input bit md);
        iWrEn   = 1'b1;
        iWrChan = 2'(ch);
        iWrDiv  = W'(dv);
        iWrMode = md;
        $display("write ch=%0d div=%0d mode=%0d t=%0t", ch, dv, md, $time);
        step();
        iWrEn = 1'b0;
    endtask

    // Counts rising edges until oTick[ch] is seen; -1 if it never comes.
    task automatic waitTick(input int ch, output int n);
        n = 0;
        repeat (64) begin
            @(posedge iClk);
            n++;
            @(negedge iClk);
            if (oTick[ch]) return;
        end
        n = -1;
    endtask

    initial begin
        int n;
        int first[3];

        // Reset state
        repeat (3) @(posedge iClk);
        #1;
        check("reset_oClk", int'(oClk), 0);
        check("reset_oTick", int'(oTick), 0);
        check("reset_oPending", int'(oPending), 0);
        @(negedge iClk);
        nRst = 1'b1;

        // Default divisor 3 on channel 0
        step();
        iEn = 4'b0001;
        waitTick(0, n);
        check("ch0_first_event", n, 3);
        check("ch0_clk_high", int'(oClk[0]), 1);
        waitTick(0, n);
        check("ch0_period", n, 3);
        check("ch0_clk_low", int'(oClk[0]), 0);
        check("others_idle", int'(oClk[3:1]), 0);

        // Mid-period divisor change on channel 0
        step();
        doWrite(0, 5, 1'b0);
        @(negedge iClk);
        check("ch0_pending_set", int'(oPending[0]), 1);
        waitTick(0, n);
        check("ch0_old_period_end", n, 1);
        check("ch0_pending_clear", int'(oPending[0]), 0);
        waitTick(0, n);
        check("ch0_new_half_period", n, 5);

        // Disabled channel 2 applies immediately; pulse mode after enable
        step();
        doWrite(2, 4, 1'b1);
        @(negedge iClk);
        check("ch2_pending_set", int'(oPending[2]), 1);
        step();
        @(negedge iClk);
        check("ch2_apply_immediate", int'(oPending[2]), 0);
        step();
        iEn = 4'b0101;
        waitTick(2, n);
        check("ch2_pulse_first", n, 4);
        check("ch2_pulse_clk", int'(oClk[2]), 1);
        waitTick(2, n);
        check("ch2_pulse_period", n, 4);

        // Halt channel 1 with div=0, then resume at div=2
        step();
        iEn = 4'b0111;
        repeat (7) step();
        doWrite(1, 0, 1'b0);
        repeat (8) step();
        @(negedge iClk);
        check("ch1_halted_clk", int'(oClk[1]), 0);
        check("ch1_halted_pend", int'(oPending[1]), 0);
        step();
        doWrite(1, 2, 1'b0);
        waitTick(1, n);
        check("ch1_resume", n, 3);

        // Phase alignment via iSync
        step();
        doWrite(0, 3, 1'b0);
        doWrite(1, 5, 1'b0);
        doWrite(2, 7, 1'b0);
        repeat (10) step();
        iSync = 1'b1;
        step();
        iSync = 1'b0;
        first = '{-1, -1, -1};
        for (int k = 1; k <= 10; k++) begin
            @(posedge iClk);
            @(negedge iClk);
            for (int c = 0; c < 3; c++)
                if (first[c] < 0 && oTick[c]) first[c] = k;
        end
        check("sync_ch0", first[0], 3);
        check("sync_ch1", first[1], 5);
        check("sync_ch2", first[2], 7);

        // Reset mid-period with a pending write
        step();
        doWrite(0, 9, 1'b0);
        #2;
        nRst = 1'b0;
        #1;
        check("async_rst_oClk", int'(oClk), 0);
        check("async_rst_oTick", int'(oTick), 0);
        check("async_rst_oPending", int'(oPending), 0);
        iEn = '0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        nRst = 1'b1;
        @(negedge iClk);
        check("post_rst_pending", int'(oPending), 0);
        step();
        iEn = 4'b0001;
        waitTick(0, n);
        check("post_rst_default_div", n, DDIV);

        // Randomized traffic, checked by the model every cycle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            iWrEn = 1'b0;
            iSync = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) iEn = 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                iWrEn   = 1'b1;
                iWrChan = 2'($urandom);
                iWrDiv  = W'($urandom_range(0, 6));
                iWrMode = 1'($urandom);
                $display("write ch=%0d div=%0d mode=%0d t=%0t", iWrChan, iWrDiv, iWrMode, $time);
            end
        end
        step();
        iWrEn = 1'b0;
        iSync = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
